// File: rtl/ref_pkg.sv
// Shared constants and helpers for the refresh scheduler slice.
package ref_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  localparam int unsigned REF_CNT_W      = 8;
  localparam int unsigned REF_URG_THR    = 224;
  localparam int unsigned REF_MAX_DEBT   = 2;
  localparam int unsigned REF_TMO_STAGES = 2;

  // Width of the Debt bus for the default configuration.
  localparam int unsigned DW = clog2(REF_MAX_DEBT + 1);

endpackage

// File: rtl/ref_debt_ctr.sv
// Saturating up/down counter of owed refreshes with overflow pulse.
module ref_debt_ctr
  import ref_pkg::*;
#(
  parameter  int unsigned MAX_DEBT = REF_MAX_DEBT,
  localparam int unsigned DBW      = clog2(MAX_DEBT + 1)
) (
  input  logic           FCLK,
  input  logic           nRES,
  input  logic           inc,
  input  logic           decReq,
  output logic [DBW-1:0] Debt,
  output logic           RefOvf
);

  logic           dec;
  logic [DBW-1:0] debtNxt;
  logic           ovfNxt;

  // A simultaneous tick and ack cancel out, even when saturated.
  always_comb begin
    debtNxt = Debt;
    ovfNxt  = 1'b0;
    dec     = decReq && (Debt != '0);
    if (inc && !dec) begin
      if (Debt < DBW'(MAX_DEBT)) debtNxt = Debt + DBW'(1);
      else                       ovfNxt  = 1'b1;
    end else if (dec && !inc) begin
      debtNxt = Debt - DBW'(1);
    end
  end

  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES) begin
      Debt   <= '0;
      RefOvf <= 1'b0;
    end else begin
      Debt   <= debtNxt;
      RefOvf <= ovfNxt;
    end
  end

endmodule

// File: rtl/ref_sched.sv
// Periodic refresh request generator with bounded debt and bus-cycle timeouts.
module ref_sched
  import ref_pkg::*;
#(
  parameter  int unsigned CNT_W      = REF_CNT_W,
  parameter  int unsigned URG_THR    = REF_URG_THR,
  parameter  int unsigned MAX_DEBT   = REF_MAX_DEBT,
  parameter  int unsigned TMO_STAGES = REF_TMO_STAGES,
  localparam int unsigned DBW        = clog2(MAX_DEBT + 1)
) (
  input  logic                  FCLK,
  input  logic                  nRES,
  input  logic                  CACT,
  input  logic                  RefAck,
  output logic                  RefReq,
  output logic                  RefUrgent,
  output logic                  RefOvf,
  output logic [DBW-1:0]        Debt,
  output logic [TMO_STAGES-1:0] Timeout
);

  if (CNT_W < 1 || CNT_W > 31) begin : gBadCntW
    $error("ref_sched: CNT_W must be 1..31");
  end
  if (URG_THR == 0 || 64'(URG_THR) >= (64'd1 << CNT_W)) begin : gBadUrgThr
    $error("ref_sched: URG_THR must satisfy 0 < URG_THR < 2**CNT_W");
  end
  if (MAX_DEBT < 1 || MAX_DEBT > 15) begin : gBadMaxDebt
    $error("ref_sched: MAX_DEBT must be 1..15");
  end
  if (TMO_STAGES < 1) begin : gBadTmo
    $error("ref_sched: TMO_STAGES must be at least 1");
  end

  logic [CNT_W-1:0]      RefCnt;
  logic                  tick;
  logic                  urgMulti;
  logic [TMO_STAGES-1:0] tmoNxt;

  // Free-running interval counter; tick marks its last count.
  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES) RefCnt <= '0;
    else       RefCnt <= RefCnt + CNT_W'(1);
  end

  assign tick = (RefCnt == '1);

  ref_debt_ctr #(
    .MAX_DEBT (MAX_DEBT)
  ) uDebt (
    .FCLK   (FCLK),
    .nRES   (nRES),
    .inc    (tick),
    .decReq (RefAck),
    .Debt   (Debt),
    .RefOvf (RefOvf)
  );

  if (MAX_DEBT >= 2) begin : gUrgMulti
    assign urgMulti = (Debt >= DBW'(2));
  end else begin : gUrgSingle
    assign urgMulti = 1'b0;
  end

  assign RefReq    = (Debt != '0);
  assign RefUrgent = urgMulti || ((Debt == DBW'(1)) && (RefCnt >= CNT_W'(URG_THR)));

  // Timeout shift chain: each tick with CACT high advances one stage; CACT low clears.
  always_comb begin
    tmoNxt = Timeout;
    if (!CACT) begin
      tmoNxt = '0;
    end else if (tick) begin
      tmoNxt[0] = 1'b1;
      for (int unsigned k = 1; k < TMO_STAGES; k++) tmoNxt[k] = Timeout[k-1];
    end
  end

  always_ff @(posedge FCLK or negedge nRES) begin
    if (!nRES) Timeout <= '0;
    else       Timeout <= tmoNxt;
  end

endmodule

// File: tb/tb_ref_sched.sv
// Directed scoreboard bench for ref_sched: default instance plus a small-parameter sweep instance.
module tb_ref_sched;
  import ref_pkg::*;

  localparam int unsigned SDW = clog2(5 + 1);

  logic FCLK = 1'b0;
  logic nRES;
  logic CACT;
  logic RefAck;
  logic RefAckS;

  logic           RefReq, RefUrgent, RefOvf;
  logic [DW-1:0]  Debt;
  logic [1:0]     Timeout;

  logic           SRefReq, SRefUrgent, SRefOvf;
  logic [SDW-1:0] SDebt;
  logic [2:0]     STimeout;

  always #5 FCLK = ~FCLK;

  ref_sched dut (
    .FCLK      (FCLK),
    .nRES      (nRES),
    .CACT      (CACT),
    .RefAck    (RefAck),
    .RefReq    (RefReq),
    .RefUrgent (RefUrgent),
    .RefOvf    (RefOvf),
    .Debt      (Debt),
    .Timeout   (Timeout)
  );

  ref_sched #(
    .CNT_W      (4),
    .URG_THR    (10),
    .MAX_DEBT   (5),
    .TMO_STAGES (3)
  ) dutS (
    .FCLK      (FCLK),
    .nRES      (nRES),
    .CACT      (CACT),
    .RefAck    (RefAckS),
    .RefReq    (SRefReq),
    .RefUrgent (SRefUrgent),
    .RefOvf    (SRefOvf),
    .Debt      (SDebt),
    .Timeout   (STimeout)
  );

  typedef enum int unsigned {
    S_REQ, S_URG, S_OVF, S_DEBT, S_TMO, S_SDEBT, S_SOVF, S_STMO, S_SREQ
  } sel_t;

  typedef struct {
    string       tag;
    sel_t        sel;
    int unsigned exp;
  } chk_t;

  chk_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   edgeCnt  = 0;

  function automatic int unsigned observe(input sel_t sel);
    case (sel)
      S_REQ:   return 32'(RefReq);
      S_URG:   return 32'(RefUrgent);
      S_OVF:   return 32'(RefOvf);
      S_DEBT:  return 32'(Debt);
      S_TMO:   return 32'(Timeout);
      S_SDEBT: return 32'(SDebt);
      S_SOVF:  return 32'(SRefOvf);
      S_STMO:  return 32'(STimeout);
      S_SREQ:  return 32'(SRefReq);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic pushExp(input string tag, input sel_t sel, input int unsigned exp);
    chk_t c;
    c.tag = tag;
    c.sel = sel;
    c.exp = exp;
    sbq.push_back(c);
  endtask

  task automatic checkAll();
    chk_t        c;
    int unsigned obs;
    while (sbq.size() > 0) begin
      c   = sbq.pop_front();
      obs = observe(c.sel);
      checks++;
      assert (obs === c.exp) else begin
        failures++;
        $error("FAIL %s at edge %0d: observed=%0d expected=%0d", c.tag, edgeCnt, obs, c.exp);
      end
    end
  endtask

  // Advance to the given edge count after reset release, then sample 1 time unit later.
  task automatic toEdge(input int target);
    while (edgeCnt < target) begin
      @(posedge FCLK);
      edgeCnt++;
    end
    #1;
  endtask

  initial begin
    nRES    = 1'b0;
    CACT    = 1'b1;
    RefAck  = 1'b0;
    RefAckS = 1'b0;

    repeat (3) @(posedge FCLK);
    #1;
    pushExp("rst_debt", S_DEBT, 0);
    pushExp("rst_req",  S_REQ,  0);
    pushExp("rst_urg",  S_URG,  0);
    pushExp("rst_ovf",  S_OVF,  0);
    pushExp("rst_tmo",  S_TMO,  0);
    checkAll();

    nRES    = 1'b1;
    edgeCnt = 0;

    // Sweep instance: 16-cycle period, five-deep debt, three timeout stages.
    pushExp("s_tmo_47", S_STMO, 3'b011);
    toEdge(47);  checkAll();
    pushExp("s_tmo_48",  S_STMO,  3'b111);
    pushExp("s_debt_48", S_SDEBT, 3);
    toEdge(48);  checkAll();
    pushExp("s_debt_80", S_SDEBT, 5);
    pushExp("s_ovf_80",  S_SOVF,  0);
    toEdge(80);  checkAll();
    pushExp("s_ovf_96",  S_SOVF,  1);
    pushExp("s_debt_96", S_SDEBT, 5);
    toEdge(96);  checkAll();
    pushExp("s_ovf_97",  S_SOVF,  0);
    pushExp("s_req_97",  S_SREQ,  1);
    toEdge(97);  checkAll();

    // Default instance: debt accrual and saturation.
    pushExp("req_255",  S_REQ,  0);
    pushExp("debt_255", S_DEBT, 0);
    pushExp("tmo_255",  S_TMO,  0);
    toEdge(255); checkAll();
    pushExp("req_256",  S_REQ,  1);
    pushExp("debt_256", S_DEBT, 1);
    pushExp("urg_256",  S_URG,  0);
    pushExp("tmo_256",  S_TMO,  2'b01);
    toEdge(256); checkAll();
    pushExp("urg_479", S_URG, 0);
    toEdge(479); checkAll();
    pushExp("urg_480", S_URG, 1);
    toEdge(480); checkAll();
    pushExp("debt_512", S_DEBT, 2);
    pushExp("urg_512",  S_URG,  1);
    pushExp("tmo_512",  S_TMO,  2'b11);
    toEdge(512); checkAll();
    pushExp("ovf_767", S_OVF, 0);
    toEdge(767); checkAll();
    pushExp("ovf_768",  S_OVF,  1);
    pushExp("debt_768", S_DEBT, 2);
    toEdge(768); checkAll();
    pushExp("ovf_769", S_OVF, 0);
    toEdge(769); checkAll();
    pushExp("ovf_1024", S_OVF, 1);
    toEdge(1024); checkAll();

    // Ack coinciding with a tick while saturated: no change, no overflow.
    toEdge(1279);
    RefAck = 1'b1;
    pushExp("simul_debt", S_DEBT, 2);
    pushExp("simul_ovf",  S_OVF,  0);
    toEdge(1280); checkAll();
    pushExp("ack_debt1", S_DEBT, 1);
    toEdge(1281); checkAll();
    pushExp("ack_debt0", S_DEBT, 0);
    pushExp("ack_req0",  S_REQ,  0);
    toEdge(1282); checkAll();
    pushExp("ack_underflow", S_DEBT, 0);
    toEdge(1283); checkAll();
    RefAck = 1'b0;

    // Timeout clear by a single low cycle, and clear winning over a tick.
    pushExp("tmo_pre_clr", S_TMO, 2'b11);
    checkAll();
    CACT = 1'b0;
    pushExp("tmo_clr", S_TMO, 2'b00);
    toEdge(1284); checkAll();
    CACT = 1'b1;
    pushExp("tmo_hold", S_TMO, 2'b00);
    toEdge(1285); checkAll();
    toEdge(1535);
    CACT = 1'b0;
    pushExp("tmo_clr_tick",  S_TMO,  2'b00);
    pushExp("debt_1536",     S_DEBT, 1);
    toEdge(1536); checkAll();
    CACT = 1'b1;
    pushExp("tmo_after_tick", S_TMO, 2'b00);
    toEdge(1537); checkAll();
    pushExp("tmo_1792",  S_TMO,  2'b01);
    pushExp("debt_1792", S_DEBT, 2);
    toEdge(1792); checkAll();
    pushExp("tmo_2048",  S_TMO,  2'b11);
    pushExp("ovf_2048",  S_OVF,  1);
    pushExp("debt_2048", S_DEBT, 2);
    toEdge(2048); checkAll();

    // Asynchronous reset between edges.
    nRES = 1'b0;
    #2;
    pushExp("arst_debt", S_DEBT,  0);
    pushExp("arst_req",  S_REQ,   0);
    pushExp("arst_urg",  S_URG,   0);
    pushExp("arst_ovf",  S_OVF,   0);
    pushExp("arst_tmo",  S_TMO,   0);
    pushExp("arst_sdbt", S_SDEBT, 0);
    checkAll();
    @(posedge FCLK);
    #1;
    nRES    = 1'b1;
    edgeCnt = 0;

    // Urgency window after restart, then an ack clears everything.
    pushExp("rs_debt_255", S_DEBT, 0);
    toEdge(255); checkAll();
    pushExp("rs_debt_256", S_DEBT, 1);
    pushExp("rs_tmo_256",  S_TMO,  2'b01);
    toEdge(256); checkAll();
    pushExp("rs_urg_479", S_URG, 0);
    toEdge(479); checkAll();
    pushExp("rs_urg_480", S_URG, 1);
    toEdge(480); checkAll();
    toEdge(489);
    RefAck = 1'b1;
    pushExp("rs_debt_490", S_DEBT, 0);
    pushExp("rs_req_490",  S_REQ,  0);
    pushExp("rs_urg_490",  S_URG,  0);
    toEdge(490); checkAll();
    RefAck = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ref_sched.md
Name: ref_sched

Overview:
- Parametrised successor to the FSB refresh/timeout counter, clocked by FCLK.
- Generates periodic DRAM refresh requests and keeps a bounded debt of owed refreshes, so up to MAX_DEBT back-to-back requests can queue instead of being dropped.
- Flags urgency and overflow of that debt.
- Provides a configurable chain of bus-cycle timeout stages, armed while CACT is high.

Parameters:
- CNT_W, 8: interval counter width; refresh period = 2^CNT_W FCLK cycles.
- URG_THR, 224: interval count at or above which a single owed refresh is urgent; legal range 0 < URG_THR < 2^CNT_W.
- MAX_DEBT, 2: maximum queued refreshes; legal range 1..15.
- TMO_STAGES, 2: number of timeout outputs; minimum 1.

Ports:
- FCLK  in  1  system FSB clock; all state on its rising edge.
- nRES  in  1  asynchronous active-low reset.
- CACT  in  1  CPU bus cycle active; low clears all timeouts.
- RefAck  in  1  one-cycle pulse: the controller has performed one refresh.
- RefReq  out  1  at least one refresh owed.
- RefUrgent  out  1  refresh must win arbitration next.
- RefOvf  out  1  one-cycle pulse: a period elapsed with debt already at MAX_DEBT.
- Debt  out  DW  current owed count; DW = clog2(MAX_DEBT+1).
- Timeout  out  TMO_STAGES  Timeout[k] is set after k+1 interval ticks with CACT held high.

Behaviour:
- Reset: while nRES is low, all of the following are 0, asynchronously: RefCnt, Debt, RefOvf, Timeout. RefReq and RefUrgent are therefore 0.
- RefCnt: CNT_W-bit free-running up-counter. Wraps from all-ones to 0. No other way to load it.
- tick = (RefCnt == 2^CNT_W-1), combinational from RefCnt.
  - First tick edge is the 2^CNT_W-th rising edge after nRES release.
  - Subsequent tick edges occur every 2^CNT_W edges.
- Debt update on each edge. Let inc = tick and dec = RefAck && Debt != 0.
  - inc and not dec: if Debt < MAX_DEBT, Debt+1. Otherwise Debt holds and RefOvf = 1 for that one cycle.
  - dec and not inc: Debt-1.
  - inc and dec together: Debt unchanged; RefOvf = 0, including when Debt == MAX_DEBT.
  - RefAck with Debt == 0: ignored, no underflow.
  - RefOvf is registered and is 0 on every edge not covered by the rule above.
- RefReq = (Debt != 0), combinational from the register.
- RefUrgent = (Debt >= 2) || (Debt == 1 && RefCnt >= URG_THR), combinational from registers.
  - When MAX_DEBT = 1, the first term is constant 0.
- Timeout chain, per edge:
  - If CACT = 0, all Timeout bits clear to 0.
  - Else on a tick: Timeout[0] <= 1 and Timeout[k] <= Timeout[k-1] for k ≥ 1.
  - Else all bits hold.
  - Bits are sticky while CACT stays high.
  - CACT low on a tick edge: the clear wins.
  - Latency: Timeout[0] rises between 1 and 2^CNT_W edges after CACT rises. Each further stage adds exactly 2^CNT_W edges.
- Timeouts are independent of Debt and RefAck.
- Reset mid-operation: pending debt is discarded. The counter restarts and the first tick edge is again the 2^CNT_W-th edge after release.
- RefAck and CACT are FCLK-synchronous; no internal synchronisers.
- Elaboration errors for illegal parameter values.

Decomposition:
- Shared package ref_pkg:
  - clog2 function.
  - Default constants REF_CNT_W, REF_URG_THR, REF_MAX_DEBT, REF_TMO_STAGES.
  - Interface-width localparam DW.
- One sub-module, ref_debt_ctr: saturating up/down Debt counter with simultaneous-event rule and RefOvf generation. Inputs inc, dec_req, FCLK, nRES.
- Interval counter and timeout chain stay in ref_sched.

Test Plan (default parameters unless stated):
- Reset release, no RefAck: RefReq rises after edge 256, Debt=1; Debt=2 after edge 512; RefOvf high for exactly the cycle after edge 768, Debt stays 2; next RefOvf after edge 1024.
- Urgency: after first tick, Debt=1 and RefCnt=0. RefUrgent = 0 until RefCnt = 224, i.e. it rises after edge 480. RefAck on edge 490 → Debt=0, RefReq=0 and RefUrgent=0 after that edge.
- Simultaneous events: Debt=2, RefAck on a tick edge → Debt stays 2, RefOvf stays 0. RefAck with Debt=0 → Debt stays 0.
- Timeouts: CACT high from reset → Timeout=2'b01 after edge 256, 2'b11 after edge 512. CACT low for one cycle → 2'b00 next edge. CACT low exactly on a tick edge → stays 2'b00.
- Async reset mid-operation: nRES low while Debt=2 and Timeout=2'b11 → all outputs 0 without a clock edge. After release, first tick is again on edge 256.
- Parameter sweep CNT_W=4, MAX_DEBT=5, TMO_STAGES=3, URG_THR=10: Debt saturates at 5 after edge 80; RefOvf after edge 96; Timeout[2] set after edge 48.
